uart_rx_sync: RTL and testbench



---
 rtl/uart_rx_sync.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sync.sv
// UART 8N1 receiver with a valid/ready byte output and frame/overrun flags.
// Optional even parity (one extra bit after bit 7) when UART_RX_PARITY_EN is defined.
module uart_rx_sync #(
    parameter int CLK_FRE   = 27,
    parameter int BAUD_RATE = 5625
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       rx_parity_err,
`endif
    output logic       rx_overrun
);

    localparam int          CYCLE     = CLK_FRE * 1000000 / BAUD_RATE;
    localparam logic [31:0] HALF_LAST = 32'(CYCLE / 2 - 1);
    localparam logic [31:0] BIT_LAST  = 32'(CYCLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [31:0] r_cycle_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_stop_bit;
    logic        w_fall;
    logic        w_half_hit;
    logic        w_bit_hit;
    logic        w_par_bad;
    logic        w_commit;

    assign w_fall     = r_rx_prev & ~r_rx_s;
    assign w_half_hit = (r_cycle_cnt == HALF_LAST);
    assign w_bit_hit  = (r_cycle_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    assign w_par_bad = ^{r_shift, r_par_bit};
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_commit = (r_state == S_DONE) & r_stop_bit & ~w_par_bad;

    // Two-flop synchronizer plus edge-detect history, idling high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_pin;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
                else        w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (w_half_hit) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                else            w_state_nxt = S_START;
            end
            S_DATA: begin
                if (w_bit_hit && (r_bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_PARITY: begin
                if (w_bit_hit) w_state_nxt = S_STOP;
                else           w_state_nxt = S_PARITY;
            end
            S_STOP: begin
                if (w_bit_hit) w_state_nxt = S_DONE;
                else           w_state_nxt = S_STOP;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timing, data shift and stop/parity capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_stop_bit  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_bit   <= 1'b0;
`endif
        end else begin
            // Counter restarts on every state change and at each data-bit boundary
            if ((r_state == S_IDLE) || (w_state_nxt != r_state) ||
                ((r_state == S_DATA) && w_bit_hit)) begin
                r_cycle_cnt <= 32'd0;
            end else begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if ((r_state == S_START) && w_half_hit) begin
                r_bit_cnt <= 3'd0;
            end else if ((r_state == S_DATA) && w_bit_hit) begin
                r_shift[r_bit_cnt] <= r_rx_s;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if ((r_state == S_STOP) && w_bit_hit) begin
                r_stop_bit <= r_rx_s;
            end
`ifdef UART_RX_PARITY_EN
            if ((r_state == S_PARITY) && w_bit_hit) begin
                r_par_bit <= r_rx_s;
            end
`endif
        end
    end

    // Byte commit, handshake and error reporting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_frame_err <= (r_state == S_DONE) & ~r_stop_bit;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= (r_state == S_DONE) & r_stop_bit & w_par_bad;
`endif
            if (w_commit) begin
                rx_data       <= r_shift;
                rx_data_valid <= 1'b1;
                if (rx_data_valid && !rx_data_ready) begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sync.sv
// Scoreboard bench for uart_rx_sync: serial frames are driven bit by bit while
// a negedge monitor pops expected bytes / error pulses from a queue.
module tb_uart_rx_sync;

    localparam int CYC = 10;

    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_FERR = 2'd1;
    localparam logic [1:0] EV_PERR = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    uart_rx_sync #(.CLK_FRE(1), .BAUD_RATE(100000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_frame_err (rx_frame_err),
`ifdef UART_RX_PARITY_EN
        .rx_parity_err(rx_parity_err),
`endif
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected nothing", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || (kind == EV_DATA && e.data !== data)) begin
                n_err++;
                $display("FAIL event: got kind %0d data %0h expected kind %0d data %0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: a handshake or error pulse seen here takes effect at the next posedge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rx_data_valid && rx_data_ready) observe(EV_DATA, rx_data);
            if (rx_frame_err) observe(EV_FERR, 8'h00);
`ifdef UART_RX_PARITY_EN
            if (rx_parity_err) observe(EV_PERR, 8'h00);
`endif
        end
    end

    // Reference model: outcome of one frame from its bit values alone
    function automatic ev_t model(input logic [7:0] d, input logic stop, input logic par);
        ev_t e;
        e.data = d;
        if (!stop) begin
            e.kind = EV_FERR;
        end else begin
`ifdef UART_RX_PARITY_EN
            e.kind = ((^d) != par) ? EV_PERR : EV_DATA;
`else
            e.kind = EV_DATA;
`endif
        end
        return e;
    endfunction

    task automatic drive_bit(input logic b);
        rx_pin = b;
        repeat (CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input bit expect_ev);
        if (expect_ev) exp_q.push_back(model(d, stop, par));
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       st;
        logic       pb;
        rst_n         = 1'b0;
        rx_pin        = 1'b1;
        rx_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", rx_data, 32'h00);
        chk("rst_valid", rx_data_valid, 32'd0);
        chk("rst_ferr", rx_frame_err, 32'd0);
        chk("rst_overrun", rx_overrun, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive_bit(1'b1);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        drain("frame_a5");

        rx_pin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        drain("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        drain("frame_err_3c");

        exp_q.push_back(model(8'h00, 1'b0, 1'b0));
        for (int i = 0; i < 15; i++) drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        drain("break");

        rx_data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_valid", rx_data_valid, 32'd1);
        chk("ovr_data", rx_data, 32'h22);
        chk("ovr_flag", rx_overrun, 32'd1);
        @(posedge clk); #1;
        exp_q.push_back(model(8'h22, 1'b1, 1'b0));
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        @(negedge clk);
        chk("ovr_valid_clr", rx_data_valid, 32'd0);
        chk("ovr_sticky", rx_overrun, 32'd1);
        drain("ovr_pop");
        rx_data_ready = 1'b1;

        d = 8'h5A;
        rx_pin = 1'b0;
        repeat (CYC) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_pin = d[4];
        repeat (CYC / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_overrun", rx_overrun, 32'd0);
        chk("midrst_data", rx_data, 32'h00);
        for (int i = 0; i < 12; i++) drive_bit(1'b1);
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        drain("after_reset_81");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        drain("parity_bad_07");
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        drain("parity_good_07");
        send_frame(8'h07, 1'b0, 1'b0, 1'b1);
        drain("parity_ferr_prio");
`endif

        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 4) != 0);
            pb = ^d;
`ifdef UART_RX_PARITY_EN
            if ($urandom_range(0, 3) == 0) pb = ~pb;
`endif
            send_frame(d, st, pb, 1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) drive_bit(1'b1);
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
